// File: rtl/e203_exu_dsp_wbck_pair_pkg.sv
// Shared definitions for the DSP write-back pair sequencer: FSM state
// encoding and the payload width helper used by the hold register.
// The instruction tag width comes from E203_ITAG_WIDTH when the core
// configuration provides it; a local fallback keeps the block standalone.
`ifndef E203_ITAG_WIDTH
`define E203_ITAG_WIDTH 4
`endif

package e203_exu_dsp_wbck_pair_pkg;

    typedef enum logic [1:0] {
        WBCK_IDLE = 2'd0,
        WBCK_LO   = 2'd1,
        WBCK_HI   = 2'd2
    } wbck_state_e;

    localparam int DSP_XLEN    = 32;
    localparam int DSP_RFIDX_W = 5;

    // Payload = wdat + wdat_1 + rdidx + itag + rdw64 + ov
    function automatic int payload_width(input int xlen, input int rfidx_w, input int itag_w);
        return 2 * xlen + rfidx_w + itag_w + 2;
    endfunction

endpackage

// File: rtl/e203_exu_dsp_wbck_hold.sv
// Payload register for one accepted DSP result. Data fields are left
// unreset (they are never observed unless the FSM is out of IDLE); the
// control fields rdw64 and ov are reset so no stale result can retire.
module e203_exu_dsp_wbck_hold
    import e203_exu_dsp_wbck_pair_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5,
    parameter int ITAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [XLEN-1:0]    wdat_d,
    input  logic [XLEN-1:0]    wdat_1_d,
    input  logic               rdw64_d,
    input  logic [RFIDX_W-1:0] rdidx_d,
    input  logic               ov_d,
    input  logic [ITAG_W-1:0]  itag_d,
    output logic [XLEN-1:0]    wdat_q,
    output logic [XLEN-1:0]    wdat_1_q,
    output logic               rdw64_q,
    output logic [RFIDX_W-1:0] rdidx_q,
    output logic               ov_q,
    output logic [ITAG_W-1:0]  itag_q
);

    localparam int PW = payload_width(XLEN, RFIDX_W, ITAG_W);
    localparam int DW = PW - 2;

    logic [DW-1:0] data_q;
    logic [1:0]    ctrl_q;

    // Data portion of the payload: load-enabled, no reset
    always_ff @(posedge clk) begin
        if (load) begin
            data_q <= {wdat_1_d, wdat_d, rdidx_d, itag_d};
        end
    end

    // Control portion of the payload: load-enabled with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= 2'b00;
        end else if (load) begin
            ctrl_q <= {rdw64_d, ov_d};
        end
    end

    assign {wdat_1_q, wdat_q, rdidx_q, itag_q} = data_q;
    assign {rdw64_q, ov_q}                     = ctrl_q;

endmodule

// File: rtl/e203_exu_dsp_wbck_pair.sv
// DSP MAC write-back sequencer: drains a 32-bit result or a 64-bit
// register pair (even register first, odd second) through the single
// regfile write port and maintains the sticky DSP overflow bit.
// Build option: E203_DSP_WBCK_B2B_EN lets a new result be accepted in
// the cycle the final beat retires, removing the per-result bubble.
module e203_exu_dsp_wbck_pair
    import e203_exu_dsp_wbck_pair_pkg::*;
#(
    parameter int XLEN    = DSP_XLEN,
    parameter int RFIDX_W = DSP_RFIDX_W,
    parameter int ITAG_W  = `E203_ITAG_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [XLEN-1:0]    i_wdat,
    input  logic [XLEN-1:0]    i_wdat_1,
    input  logic               i_rdw64,
    input  logic [RFIDX_W-1:0] i_rdidx,
    input  logic               i_ov,
    input  logic [ITAG_W-1:0]  i_itag,
    output logic               o_wbck_valid,
    input  logic               o_wbck_ready,
    output logic [XLEN-1:0]    o_wbck_wdat,
    output logic [RFIDX_W-1:0] o_wbck_rdidx,
    output logic               o_wbck_last,
    output logic [ITAG_W-1:0]  o_wbck_itag,
    output logic               o_misalign,
    input  logic               ov_clr,
    output logic               ov_sticky,
    output logic               ov_set
);

    wbck_state_e        state;
    logic               accept;
    logic               beat_hs;
    logic               last_hs;

    logic [XLEN-1:0]    hold_wdat;
    logic [XLEN-1:0]    hold_wdat_1;
    logic               hold_rdw64;
    logic [RFIDX_W-1:0] hold_rdidx;
    logic               hold_ov;
    logic [ITAG_W-1:0]  hold_itag;

    e203_exu_dsp_wbck_hold #(
        .XLEN    (XLEN),
        .RFIDX_W (RFIDX_W),
        .ITAG_W  (ITAG_W)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .wdat_d   (i_wdat),
        .wdat_1_d (i_wdat_1),
        .rdw64_d  (i_rdw64),
        .rdidx_d  (i_rdidx),
        .ov_d     (i_ov),
        .itag_d   (i_itag),
        .wdat_q   (hold_wdat),
        .wdat_1_q (hold_wdat_1),
        .rdw64_q  (hold_rdw64),
        .rdidx_q  (hold_rdidx),
        .ov_q     (hold_ov),
        .itag_q   (hold_itag)
    );

    assign o_wbck_valid = (state != WBCK_IDLE);
    assign beat_hs      = o_wbck_valid & o_wbck_ready;
    assign last_hs      = beat_hs & o_wbck_last;

`ifdef E203_DSP_WBCK_B2B_EN
    assign i_ready = ~rst & ((state == WBCK_IDLE) | last_hs);
`else
    assign i_ready = ~rst & (state == WBCK_IDLE);
`endif

    assign accept     = i_valid & i_ready;
    assign o_misalign = accept & i_rdw64 & i_rdidx[0];
    assign ov_set     = ~rst & last_hs & hold_ov;

    // Sequencer FSM: a pair visits LO then HI, a single word only LO
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WBCK_IDLE;
        end else begin
            case (state)
                WBCK_IDLE: if (accept)  state <= WBCK_LO;
                WBCK_LO:   if (beat_hs) state <= hold_rdw64 ? WBCK_HI : (accept ? WBCK_LO : WBCK_IDLE);
                WBCK_HI:   if (beat_hs) state <= accept ? WBCK_LO : WBCK_IDLE;
                default:   state <= WBCK_IDLE;
            endcase
        end
    end

    // Beat decode from state and payload registers; zero whenever idle
    always_comb begin
        o_wbck_wdat  = '0;
        o_wbck_rdidx = '0;
        o_wbck_last  = 1'b0;
        o_wbck_itag  = '0;
        case (state)
            WBCK_LO: begin
                o_wbck_wdat  = hold_wdat;
                o_wbck_rdidx = hold_rdw64 ? {hold_rdidx[RFIDX_W-1:1], 1'b0} : hold_rdidx;
                o_wbck_last  = ~hold_rdw64;
                o_wbck_itag  = hold_itag;
            end
            WBCK_HI: begin
                o_wbck_wdat  = hold_wdat_1;
                o_wbck_rdidx = {hold_rdidx[RFIDX_W-1:1], 1'b1};
                o_wbck_last  = 1'b1;
                o_wbck_itag  = hold_itag;
            end
            default: ;
        endcase
    end

    // Sticky overflow: a retiring overflowed result beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ov_sticky <= 1'b0;
        end else if (ov_set) begin
            ov_sticky <= 1'b1;
        end else if (ov_clr) begin
            ov_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_e203_exu_dsp_wbck_pair.sv
// Directed self-checking bench for e203_exu_dsp_wbck_pair. Inputs change
// on the falling edge and outputs are sampled 1 time unit later, so each
// falling-edge slot corresponds to one rising-edge cycle of the DUT.
`ifndef E203_ITAG_WIDTH
`define E203_ITAG_WIDTH 4
`endif

module tb_e203_exu_dsp_wbck_pair;

    localparam int XLEN    = 32;
    localparam int RFIDX_W = 5;
    localparam int ITAG_W  = `E203_ITAG_WIDTH;

    logic               clk;
    logic               rst;
    logic               i_valid;
    logic               i_ready;
    logic [XLEN-1:0]    i_wdat;
    logic [XLEN-1:0]    i_wdat_1;
    logic               i_rdw64;
    logic [RFIDX_W-1:0] i_rdidx;
    logic               i_ov;
    logic [ITAG_W-1:0]  i_itag;
    logic               o_wbck_valid;
    logic               o_wbck_ready;
    logic [XLEN-1:0]    o_wbck_wdat;
    logic [RFIDX_W-1:0] o_wbck_rdidx;
    logic               o_wbck_last;
    logic [ITAG_W-1:0]  o_wbck_itag;
    logic               o_misalign;
    logic               ov_clr;
    logic               ov_sticky;
    logic               ov_set;

    int checks;
    int errors;

    e203_exu_dsp_wbck_pair #(
        .XLEN    (XLEN),
        .RFIDX_W (RFIDX_W),
        .ITAG_W  (ITAG_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_ready      (i_ready),
        .i_wdat       (i_wdat),
        .i_wdat_1     (i_wdat_1),
        .i_rdw64      (i_rdw64),
        .i_rdidx      (i_rdidx),
        .i_ov         (i_ov),
        .i_itag       (i_itag),
        .o_wbck_valid (o_wbck_valid),
        .o_wbck_ready (o_wbck_ready),
        .o_wbck_wdat  (o_wbck_wdat),
        .o_wbck_rdidx (o_wbck_rdidx),
        .o_wbck_last  (o_wbck_last),
        .o_wbck_itag  (o_wbck_itag),
        .o_misalign   (o_misalign),
        .ov_clr       (ov_clr),
        .ov_sticky    (ov_sticky),
        .ov_set       (ov_set)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to the next falling-edge slot
    task automatic next_slot();
        @(negedge clk);
    endtask

    task automatic drive_result(input logic v, input logic [31:0] w0, input logic [31:0] w1,
                                input logic r64, input logic [4:0] idx, input logic ov,
                                input logic [ITAG_W-1:0] tag);
        i_valid  = v;
        i_wdat   = w0;
        i_wdat_1 = w1;
        i_rdw64  = r64;
        i_rdidx  = idx;
        i_ov     = ov;
        i_itag   = tag;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        o_wbck_ready = 1'b1;
        ov_clr = 1'b0;
        drive_result(1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 5'd3, 1'b1, ITAG_W'(1));
        next_slot();
        next_slot();
        #1;
        checks++;
        if ({o_wbck_valid, o_wbck_last, o_misalign, ov_sticky, ov_set, i_ready} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got v=%b last=%b mis=%b ovs=%b ovset=%b rdy=%b, want all 0",
                     o_wbck_valid, o_wbck_last, o_misalign, ov_sticky, ov_set, i_ready);
        end
        checks++;
        if (o_wbck_wdat !== 32'h0 || o_wbck_rdidx !== 5'd0 || o_wbck_itag !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got wdat=%h rdidx=%0d itag=%0d, want 0/0/0",
                     o_wbck_wdat, o_wbck_rdidx, o_wbck_itag);
        end
        next_slot();
        rst = 1'b0;
        drive_result(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, '0);
        #1;
        checks++;
        if (i_ready !== 1'b1 || o_wbck_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: got rdy=%b v=%b, want 1/0", i_ready, o_wbck_valid);
        end
    endtask

    task automatic test_single();
        next_slot();
        drive_result(1'b1, 32'h12345678, 32'h0, 1'b0, 5'd7, 1'b0, ITAG_W'(3));
        #1;
        checks++;
        if (i_ready !== 1'b1 || o_misalign !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_accept: got rdy=%b mis=%b, want 1/0", i_ready, o_misalign);
        end
        next_slot();
        drive_result(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, '0);
        #1;
        checks++;
        if (o_wbck_valid !== 1'b1 || o_wbck_wdat !== 32'h12345678 || o_wbck_rdidx !== 5'd7 ||
            o_wbck_last !== 1'b1 || o_wbck_itag !== ITAG_W'(3)) begin
            errors++;
            $display("[TB] FAIL single_beat: got v=%b wdat=%h rd=%0d last=%b tag=%0d, want 1/12345678/7/1/3",
                     o_wbck_valid, o_wbck_wdat, o_wbck_rdidx, o_wbck_last, o_wbck_itag);
        end
        next_slot();
        #1;
        checks++;
        if (o_wbck_valid !== 1'b0 || i_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_idle: got v=%b rdy=%b, want 0/1", o_wbck_valid, i_ready);
        end
    endtask

    task automatic test_pair();
        next_slot();
        drive_result(1'b1, 32'hAAAA0001, 32'hBBBB0002, 1'b1, 5'd10, 1'b0, ITAG_W'(5));
        next_slot();
        drive_result(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, '0);
        #1;
        checks++;
        if (o_wbck_valid !== 1'b1 || o_wbck_wdat !== 32'hAAAA0001 || o_wbck_rdidx !== 5'd10 ||
            o_wbck_last !== 1'b0 || o_wbck_itag !== ITAG_W'(5)) begin
            errors++;
            $display("[TB] FAIL pair_beat0: got v=%b wdat=%h rd=%0d last=%b tag=%0d, want 1/aaaa0001/10/0/5",
                     o_wbck_valid, o_wbck_wdat, o_wbck_rdidx, o_wbck_last, o_wbck_itag);
        end
        next_slot();
        #1;
        checks++;
        if (o_wbck_valid !== 1'b1 || o_wbck_wdat !== 32'hBBBB0002 || o_wbck_rdidx !== 5'd11 ||
            o_wbck_last !== 1'b1 || o_wbck_itag !== ITAG_W'(5)) begin
            errors++;
            $display("[TB] FAIL pair_beat1: got v=%b wdat=%h rd=%0d last=%b tag=%0d, want 1/bbbb0002/11/1/5",
                     o_wbck_valid, o_wbck_wdat, o_wbck_rdidx, o_wbck_last, o_wbck_itag);
        end
        next_slot();
        #1;
        checks++;
        if (o_wbck_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pair_idle: got v=%b, want 0", o_wbck_valid);
        end
    endtask

    task automatic test_stall();
        next_slot();
        drive_result(1'b1, 32'h11111111, 32'h22222222, 1'b1, 5'd12, 1'b0, ITAG_W'(2));
        o_wbck_ready = 1'b0;
        next_slot();
        drive_result(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (o_wbck_valid !== 1'b1 || o_wbck_wdat !== 32'h11111111 || o_wbck_rdidx !== 5'd12 ||
                o_wbck_last !== 1'b0 || i_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: got v=%b wdat=%h rd=%0d last=%b rdy=%b, want 1/11111111/12/0/0",
                         k, o_wbck_valid, o_wbck_wdat, o_wbck_rdidx, o_wbck_last, i_ready);
            end
            next_slot();
        end
        o_wbck_ready = 1'b1;
        #1;
        checks++;
        if (o_wbck_wdat !== 32'h11111111 || o_wbck_rdidx !== 5'd12) begin
            errors++;
            $display("[TB] FAIL stall_release: got wdat=%h rd=%0d, want 11111111/12", o_wbck_wdat, o_wbck_rdidx);
        end
        next_slot();
        #1;
        checks++;
        if (o_wbck_wdat !== 32'h22222222 || o_wbck_rdidx !== 5'd13 || o_wbck_last !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_beat1: got wdat=%h rd=%0d last=%b, want 22222222/13/1",
                     o_wbck_wdat, o_wbck_rdidx, o_wbck_last);
        end
        next_slot();
    endtask

    task automatic test_misalign();
        next_slot();
        drive_result(1'b1, 32'h44440004, 32'h55550005, 1'b1, 5'd5, 1'b0, ITAG_W'(6));
        #1;
        checks++;
        if (o_misalign !== 1'b1) begin
            errors++;
            $display("[TB] FAIL misalign_pulse: got %b, want 1", o_misalign);
        end
        next_slot();
        drive_result(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, '0);
        #1;
        checks++;
        if (o_misalign !== 1'b0 || o_wbck_rdidx !== 5'd4 || o_wbck_wdat !== 32'h44440004 || o_wbck_last !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misalign_beat0: got mis=%b rd=%0d wdat=%h last=%b, want 0/4/44440004/0",
                     o_misalign, o_wbck_rdidx, o_wbck_wdat, o_wbck_last);
        end
        next_slot();
        #1;
        checks++;
        if (o_wbck_rdidx !== 5'd5 || o_wbck_wdat !== 32'h55550005 || o_wbck_last !== 1'b1) begin
            errors++;
            $display("[TB] FAIL misalign_beat1: got rd=%0d wdat=%h last=%b, want 5/55550005/1",
                     o_wbck_rdidx, o_wbck_wdat, o_wbck_last);
        end
        next_slot();
    endtask

    task automatic test_overflow();
        next_slot();
        drive_result(1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b1, 5'd2, 1'b1, ITAG_W'(7));
        #1;
        checks++;
        if (ov_set !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ov_accept: got ov_set=%b, want 0", ov_set);
        end
        next_slot();
        drive_result(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, '0);
        #1;
        checks++;
        if (ov_set !== 1'b0 || ov_sticky !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ov_beat0: got ov_set=%b ovs=%b, want 0/0", ov_set, ov_sticky);
        end
        next_slot();
        ov_clr = 1'b1;
        #1;
        checks++;
        if (ov_set !== 1'b1 || o_wbck_last !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ov_set_pulse: got ov_set=%b last=%b, want 1/1", ov_set, o_wbck_last);
        end
        next_slot();
        ov_clr = 1'b0;
        #1;
        checks++;
        if (ov_sticky !== 1'b1 || ov_set !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ov_set_wins: got ovs=%b ov_set=%b, want 1/0", ov_sticky, ov_set);
        end
        next_slot();
        ov_clr = 1'b1;
        next_slot();
        ov_clr = 1'b0;
        #1;
        checks++;
        if (ov_sticky !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ov_clear: got ovs=%b, want 0", ov_sticky);
        end
    endtask

    task automatic test_reset_mid_pair();
        next_slot();
        drive_result(1'b1, 32'h01010101, 32'h02020202, 1'b1, 5'd8, 1'b1, ITAG_W'(4));
        next_slot();
        drive_result(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, '0);
        next_slot();
        rst = 1'b1;
        #1;
        checks++;
        if (ov_set !== 1'b0 || i_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_hi_ovset: got ov_set=%b rdy=%b, want 0/0", ov_set, i_ready);
        end
        next_slot();
        rst = 1'b0;
        #1;
        checks++;
        if (o_wbck_valid !== 1'b0 || ov_sticky !== 1'b0 || o_wbck_wdat !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_hi_abandon: got v=%b ovs=%b wdat=%h, want 0/0/0",
                     o_wbck_valid, ov_sticky, o_wbck_wdat);
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        int ret;
        int cyc;
        int first_acc;
        int last_ret;
        int exp_span;
`ifdef E203_DSP_WBCK_B2B_EN
        exp_span = 5;
`else
        exp_span = 8;
`endif
        acc = 0;
        ret = 0;
        cyc = 0;
        first_acc = -1;
        last_ret = -1;
        o_wbck_ready = 1'b1;
        while (ret < 4 && cyc < 40) begin
            next_slot();
            drive_result(acc < 4, 32'hC0DE0000 + 32'(acc), 32'h0, 1'b0, 5'(acc + 1), 1'b0, ITAG_W'(acc));
            #1;
            if (o_wbck_valid && o_wbck_ready && o_wbck_last) begin
                checks++;
                if (o_wbck_wdat !== 32'hC0DE0000 + 32'(ret) || o_wbck_rdidx !== 5'(ret + 1)) begin
                    errors++;
                    $display("[TB] FAIL b2b_data%0d: got wdat=%h rd=%0d, want %h/%0d",
                             ret, o_wbck_wdat, o_wbck_rdidx, 32'hC0DE0000 + 32'(ret), ret + 1);
                end
                ret++;
                last_ret = cyc;
            end
            if (i_valid && i_ready) begin
                if (first_acc < 0) first_acc = cyc;
                acc++;
            end
            cyc++;
        end
        drive_result(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, '0);
        checks++;
        if (ret != 4) begin
            errors++;
            $display("[TB] FAIL b2b_timeout: got %0d retirements in %0d cycles, want 4", ret, cyc);
        end else if (last_ret - first_acc + 1 != exp_span) begin
            errors++;
            $display("[TB] FAIL b2b_span: got %0d cycles, want %0d", last_ret - first_acc + 1, exp_span);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_pair();
        test_stall();
        test_misalign();
        test_overflow();
        test_reset_mid_pair();
        test_back_to_back();
        next_slot();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/e203_exu_dsp_wbck_pair.md
# e203_exu_dsp_wbck_pair

Write-back sequencer on the consumer side of the DSP MAC adder. It accepts one finished DSP result per handshake: a 32-bit word, or a 64-bit pair for rdw64/concat ops, plus the saturation-overflow flag. It drains each result into the single integer-regfile write port, one beat per register: even register first, odd register second. It also maintains the sticky DSP overflow (OV) bit exported to the CSR file.

## Interface
Parameters:
- XLEN, 32, data width of one beat.
- RFIDX_W, 5, register index width.
- ITAG_W, `E203_ITAG_WIDTH, instruction tag width.

Ports:
- clk  in  1  the block's only clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  result valid from the MAC adder.
- i_ready  out  1  sequencer can capture a result.
- i_wdat  in  XLEN  low word (the adder's wdat).
- i_wdat_1  in  XLEN  high word (the adder's wdat_1); ignored unless i_rdw64=1.
- i_rdw64  in  1  result is a 64-bit register pair.
- i_rdidx  in  RFIDX_W  destination register index.
- i_ov  in  1  overflow/saturation occurred for this result.
- i_itag  in  ITAG_W  instruction tag.
- o_wbck_valid  out  1  write beat valid.
- o_wbck_ready  in  1  regfile port accepts the beat.
- o_wbck_wdat  out  XLEN  beat data.
- o_wbck_rdidx  out  RFIDX_W  beat register index.
- o_wbck_last  out  1  final beat of the current result.
- o_wbck_itag  out  ITAG_W  tag of the current result, held for every beat.
- o_misalign  out  1  one-cycle pulse: a 64-bit result was accepted with odd i_rdidx.
- ov_clr  in  1  CSR write clearing the sticky OV bit.
- ov_sticky  out  1  sticky OV bit.
- ov_set  out  1  one-cycle pulse: the sticky bit was set by a retiring result.

## Operation
FSM states:
- IDLE: no beat pending.
- LO: beat 0 presented.
- HI: beat 1 presented.

Capture and beat contents:
- A result is accepted on i_valid & i_ready. Accepting latches a payload register with wdat, wdat_1, rdw64, rdidx, ov and itag.
- Beat 0, single-word result: wdat to rdidx, o_wbck_last=1.
- Beat 0, pair result: wdat to {rdidx[RFIDX_W-1:1],1'b0}, o_wbck_last=0.
- Beat 1 (pair results only): wdat_1 to {rdidx[RFIDX_W-1:1],1'b1}, o_wbck_last=1.
- Pair result with i_rdidx[0]=1: the index LSB is forced as above, and o_misalign pulses in the accept cycle. The write sequence is unchanged.

Transitions:
- IDLE→LO on accept.
- LO→HI on beat handshake when rdw64=1.
- LO→IDLE on beat handshake when rdw64=0.
- HI→IDLE on beat handshake.
- Back-to-back (only with E203_DSP_WBCK_B2B_EN): a last-beat handshake that coincides with an accept goes to LO with the new payload.

Output and stall rules:
- o_wbck_valid=1 exactly in LO and HI.
- All o_wbck_* outputs are driven from registers and stay stable while o_wbck_valid=1 & ~o_wbck_ready.

Overflow:
- On the last-beat handshake of a result with latched ov=1: ov_sticky←1 and ov_set pulses in that cycle.
- ov_clr clears ov_sticky. If ov_clr and a set occur in the same cycle, set wins.
- OV is never set at accept time. A result still in flight at reset contributes nothing.

Reset:
- While rst=1 the FSM goes to IDLE and i_ready=0.
- Outputs during reset: o_wbck_valid=0, o_wbck_wdat=0, o_wbck_rdidx=0, o_wbck_last=0, o_wbck_itag=0, o_misalign=0, ov_sticky=0, ov_set=0.
- Reset mid-pair abandons beat 1. The even register may already be written; software re-executes.

## Timing
- i_ready (combinational) = ~rst & (state==IDLE).
- With E203_DSP_WBCK_B2B_EN, i_ready additionally = 1 when in LO/HI on the last beat with o_wbck_ready=1.
- Accept at cycle N → beat 0 visible at N+1.
- Pair result: beat 1 no earlier than N+2.
- Minimum occupancy: 1 cycle for a single-word result, 2 cycles for a pair.
- o_misalign pulses in cycle N.
- ov_set pulses in the last-beat handshake cycle; ov_sticky reads 1 from the next cycle.

## Configuration
- Macro: E203_DSP_WBCK_B2B_EN.
- Defined: i_ready also rises during the final beat when o_wbck_ready=1. Sustained single-word results then retire one per cycle.
- Undefined: i_ready=1 only in IDLE. Each result then costs one extra bubble cycle.
- Beat contents and OV behaviour are identical in both builds.

## Structure
- Shared package/defines: FSM state encoding (IDLE/LO/HI, 2-bit) and the payload width constant 2*XLEN+RFIDX_W+ITAG_W+2.
- Natural sub-module: e203_exu_dsp_wbck_hold, the payload register with load enable. Data bits are not reset; the control bits (rdw64, ov) are reset.

## Test plan
- Single word: accept wdat=0x12345678, rdidx=7, rdw64=0 with o_wbck_ready=1 → at N+1 one beat: wdat 0x12345678 to x7, last=1; then IDLE.
- Pair: accept rdidx=10, wdat=0xAAAA0001, wdat_1=0xBBBB0002 → beat 0xAAAA0001 to x10, then beat 0xBBBB0002 to x11 with last=1.
- Stall: o_wbck_ready=0 for 3 cycles during beat 0 → outputs held constant, i_ready=0, no beat 1 until the handshake.
- Misalign: pair result with rdidx=5 → o_misalign pulse at accept; writes go to x4 then x5.
- Overflow: pair result with ov=1, ov_clr=1 asserted in the last-beat cycle → ov_set pulses, ov_sticky=1 next cycle. A later ov_clr alone → 0.
- Reset mid-pair / back-to-back: rst during HI → o_wbck_valid=0 next cycle and no ov_set. With the B2B macro, 4 consecutive single-word results retire in 4 consecutive cycles; without it they take 8.
